// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the SRAM-like request arbiter: master tags and the request bundle.
package sram_req_arbiter_pkg;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    typedef enum logic {
        ARB_INST = 1'b0,
        ARB_DATA = 1'b1
    } arb_master_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        virt_t       addr;
        uint32_t     wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order tag FIFO (1-bit payload) recording which master issued each accepted request.
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           din,
    input  logic                           pop,
    output logic                           head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so pointer wrap is the natural counter overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges instruction and data SRAM-like masters onto one slave port with in-order response routing.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data-over-inst priority.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,

    input  logic                                   inst_req,
    input  logic                                   inst_wr,
    input  logic [1:0]                             inst_size,
    input  logic [3:0]                             inst_wstrb,
    input  logic [31:0]                            inst_addr,
    input  logic [31:0]                            inst_wdata,
    output logic                                   inst_addr_ok,
    output logic                                   inst_data_ok,
    output logic [31:0]                            inst_rdata,

    input  logic                                   data_req,
    input  logic                                   data_wr,
    input  logic [1:0]                             data_size,
    input  logic [3:0]                             data_wstrb,
    input  logic [31:0]                            data_addr,
    input  logic [31:0]                            data_wdata,
    output logic                                   data_addr_ok,
    output logic                                   data_data_ok,
    output logic [31:0]                            data_rdata,

    output logic                                   s_req,
    output logic                                   s_wr,
    output logic [1:0]                             s_size,
    output logic [3:0]                             s_wstrb,
    output logic [31:0]                            s_addr,
    output logic [31:0]                            s_wdata,
    input  logic                                   s_addr_ok,
    input  logic                                   s_data_ok,
    input  logic [31:0]                            s_rdata,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   proto_err
);
    logic        lock_valid;
    arb_master_e lock_master;
    logic        grant_valid;
    arb_master_e grant;
    logic        granted_req;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_head;
    logic        push;
    logic        pop;
    sram_req_t   inst_fields;
    sram_req_t   data_fields;
    sram_req_t   s_fields;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    arb_master_e last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ARB_INST;
        end else if (push) begin
            last_grant <= grant;
        end
    end
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant       = ARB_DATA;
        if (lock_valid) begin
            grant_valid = 1'b1;
            grant       = lock_master;
        end else if (inst_req && data_req) begin
            grant_valid = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            grant       = (last_grant == ARB_INST) ? ARB_DATA : ARB_INST;
`else
            grant       = ARB_DATA;
`endif
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant       = ARB_INST;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant       = ARB_DATA;
        end
    end

    assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                           addr: inst_addr, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                           addr: data_addr, wdata: data_wdata};

    // With no grant, grant defaults to DATA so the bus carries the data master's fields.
    assign s_fields    = (grant == ARB_INST) ? inst_fields : data_fields;
    assign granted_req = (grant == ARB_INST) ? inst_req : data_req;

    assign s_req   = grant_valid & granted_req & ~fifo_full & ~reset;
    assign s_wr    = s_fields.wr;
    assign s_size  = s_fields.size;
    assign s_wstrb = s_fields.wstrb;
    assign s_addr  = s_fields.addr;
    assign s_wdata = s_fields.wdata;

    assign push         = s_req & s_addr_ok;
    assign inst_addr_ok = push & (grant == ARB_INST);
    assign data_addr_ok = push & (grant == ARB_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid  <= 1'b0;
            lock_master <= ARB_INST;
        end else if (s_req && !s_addr_ok) begin
            lock_valid  <= 1'b1;
            lock_master <= grant;
        end else if (push) begin
            lock_valid  <= 1'b0;
        end
    end

    assign pop          = s_data_ok & ~fifo_empty & ~reset;
    assign inst_data_ok = pop & (arb_master_e'(fifo_head) == ARB_INST);
    assign data_data_ok = pop & (arb_master_e'(fifo_head) == ARB_DATA);
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

    // A response with nothing outstanding means the bridge and arbiter disagree; latch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (s_data_ok && fifo_empty) begin
            proto_err <= 1'b1;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (grant),
        .pop   (pop),
        .head  (fifo_head),
        .count (outstanding),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
